// File: rtl/jelly_axi4_write_burst_split.sv
// Splits a long AXI4 write command into legal bursts and regenerates wlast on W.
// Latency: s_aw handshake to m_awvalid takes 2 cycles; W is a combinational pass-through.
// Backpressure: AW stalls in CALC while the burst-length FIFO is full; W stalls until a burst length is queued.

// Small burst-length FIFO with show-ahead read.
// Latency: a pushed entry is visible on rd_data the cycle after the push.
// Backpressure: the caller must not push when full or pop when empty.
module jelly_axi4_write_burst_split_fifo #(
  parameter int WIDTH     = 8,
  parameter int PTR_WIDTH = 4
) (
  input  logic             reset,
  input  logic             clk,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  logic [WIDTH-1:0]   mem [2**PTR_WIDTH];
  logic [PTR_WIDTH:0] wr_ptr;
  logic [PTR_WIDTH:0] rd_ptr;

  // Pointer update; the extra MSB separates full from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (PTR_WIDTH+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (PTR_WIDTH+1)'(1);
    end
  end

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[PTR_WIDTH-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[PTR_WIDTH-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]) &&
                   (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]);

endmodule

module jelly_axi4_write_burst_split #(
  parameter int ADDR_WIDTH         = 49,
  parameter int DATA_SIZE          = 3,
  parameter int DATA_WIDTH         = (8 << DATA_SIZE),
  parameter int STRB_WIDTH         = DATA_WIDTH / 8,
  parameter int S_LEN_WIDTH        = 32,
  parameter int S_LEN_OFFSET       = 1,
  parameter int M_LEN_WIDTH        = 8,
  parameter int MAX_BURST          = 256,
  parameter int BOUNDARY_BITS      = 12,
  parameter int CMD_FIFO_PTR_WIDTH = 4
) (
  input  logic                   reset,
  input  logic                   clk,

  input  logic [ADDR_WIDTH-1:0]  s_awaddr,
  input  logic [S_LEN_WIDTH-1:0] s_awlen,
  input  logic                   s_awvalid,
  output logic                   s_awready,

  input  logic [DATA_WIDTH-1:0]  s_wdata,
  input  logic [STRB_WIDTH-1:0]  s_wstrb,
  input  logic                   s_wvalid,
  output logic                   s_wready,

  output logic [ADDR_WIDTH-1:0]  m_awaddr,
  output logic [M_LEN_WIDTH-1:0] m_awlen,
  output logic                   m_awvalid,
  input  logic                   m_awready,

  output logic [DATA_WIDTH-1:0]  m_wdata,
  output logic [STRB_WIDTH-1:0]  m_wstrb,
  output logic                   m_wlast,
  output logic                   m_wvalid,
  input  logic                   m_wready
);

  localparam int REM_W  = S_LEN_WIDTH + 1;
  localparam int PAGE_W = BOUNDARY_BITS - DATA_SIZE;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ~((ADDR_WIDTH'(1) << DATA_SIZE) - ADDR_WIDTH'(1));

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [REM_W-1:0]        rem;
  logic [REM_W-1:0]        burst;
  logic [REM_W-1:0]        burst_calc;
  logic [REM_W-1:0]        s_rem;
  logic [PAGE_W:0]         page_beats;
  logic                    awready_q;
  logic [ADDR_WIDTH-1:0]   awaddr_q;
  logic [M_LEN_WIDTH-1:0]  awlen_q;

  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [M_LEN_WIDTH-1:0]  cmd_len;
  logic                    cmd_valid;
  logic [M_LEN_WIDTH-1:0]  beat_cnt;
  logic                    w_hs;

  assign s_rem      = REM_W'(s_awlen) + REM_W'(S_LEN_OFFSET);
  assign page_beats = {1'b1, {PAGE_W{1'b0}}} - {1'b0, addr[BOUNDARY_BITS-1:DATA_SIZE]};

  // Burst size: the smallest of remaining beats, the burst cap and the beats left in this page.
  always_comb begin
    burst_calc = rem;
    if (burst_calc > REM_W'(MAX_BURST))  burst_calc = REM_W'(MAX_BURST);
    if (burst_calc > REM_W'(page_beats)) burst_calc = REM_W'(page_beats);
  end

  // AW state register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // AW next-state and FIFO push; CALC waits for FIFO room so W always finds its length.
  always_comb begin
    state_next = state;
    fifo_push  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s_awvalid && awready_q && (s_rem != '0)) state_next = ST_CALC;
      end
      ST_CALC: begin
        if (!fifo_full) begin
          fifo_push  = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (m_awready) state_next = (rem == burst) ? ST_IDLE : ST_CALC;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // AW datapath: latch the command, register each burst, advance address and remainder.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr      <= '0;
      rem       <= '0;
      burst     <= '0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      awready_q <= 1'b0;
    end else begin
      awready_q <= (state_next == ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (s_awvalid && awready_q) begin
            addr <= s_awaddr;
            rem  <= s_rem;
          end
        end
        ST_CALC: begin
          if (!fifo_full) begin
            awaddr_q <= addr;
            awlen_q  <= M_LEN_WIDTH'(burst_calc - REM_W'(1));
            burst    <= burst_calc;
          end
        end
        ST_ISSUE: begin
          if (m_awready) begin
            // Only the first burst keeps the unaligned low address bits.
            addr <= (addr & ALIGN_MASK) + (ADDR_WIDTH'(burst) << DATA_SIZE);
            rem  <= rem - burst;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_awready = awready_q;
  assign m_awvalid = (state == ST_ISSUE);
  assign m_awaddr  = awaddr_q;
  assign m_awlen   = awlen_q;

  jelly_axi4_write_burst_split_fifo #(
    .WIDTH     (M_LEN_WIDTH),
    .PTR_WIDTH (CMD_FIFO_PTR_WIDTH)
  ) u_cmd_fifo (
    .reset   (reset),
    .clk     (clk),
    .wr_en   (fifo_push),
    .wr_data (M_LEN_WIDTH'(burst_calc - REM_W'(1))),
    .full    (fifo_full),
    .rd_en   (fifo_pop),
    .rd_data (cmd_len),
    .empty   (fifo_empty)
  );

  assign cmd_valid = !fifo_empty;
  assign m_wvalid  = s_wvalid & cmd_valid;
  assign s_wready  = m_wready & cmd_valid;
  assign m_wdata   = s_wdata;
  assign m_wstrb   = s_wstrb;
  assign m_wlast   = cmd_valid && (beat_cnt == cmd_len);
  assign w_hs      = m_wvalid & m_wready;
  assign fifo_pop  = w_hs & m_wlast;

  // Beat counter within the current burst; wraps to zero on the last beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt <= '0;
    end else if (w_hs) begin
      if (m_wlast) beat_cnt <= '0;
      else         beat_cnt <= beat_cnt + M_LEN_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_jelly_axi4_write_burst_split.sv
// Randomized bench for the write burst splitter with a queue-based reference model.
// Expected bursts and wlast flags are queued per command; expected data per driven beat.
// A negedge monitor pops and compares on every m_aw and m_w handshake.
module tb_jelly_axi4_write_burst_split;

  localparam int AW  = 49;
  localparam int DW  = 64;
  localparam int SW  = 8;
  localparam int LW  = 32;
  localparam int MLW = 8;
  localparam int TMO = 5000;

  logic           reset;
  logic           clk;
  logic [AW-1:0]  s_awaddr;
  logic [LW-1:0]  s_awlen;
  logic           s_awvalid;
  logic           s_awready;
  logic [DW-1:0]  s_wdata;
  logic [SW-1:0]  s_wstrb;
  logic           s_wvalid;
  logic           s_wready;
  logic [AW-1:0]  m_awaddr;
  logic [MLW-1:0] m_awlen;
  logic           m_awvalid;
  logic           m_awready;
  logic [DW-1:0]  m_wdata;
  logic [SW-1:0]  m_wstrb;
  logic           m_wlast;
  logic           m_wvalid;
  logic           m_wready;

  jelly_axi4_write_burst_split dut (
    .reset     (reset),
    .clk       (clk),
    .s_awaddr  (s_awaddr),
    .s_awlen   (s_awlen),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .m_awaddr  (m_awaddr),
    .m_awlen   (m_awlen),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_wlast   (m_wlast),
    .m_wvalid  (m_wvalid),
    .m_wready  (m_wready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0]  exp_awaddr[$];
  logic [MLW-1:0] exp_awlen[$];
  bit             exp_last[$];
  logic [DW-1:0]  exp_data[$];
  logic [SW-1:0]  exp_strb[$];

  int          errors = 0;
  int          checks = 0;
  bit          abort  = 0;
  int          aw_pct = 100;
  int          w_pct  = 100;
  int unsigned hs_cyc = 0;
  int          aw_hs  = 0;
  longint      aw_beat_sum = 0;
  logic [DW-1:0] ramp = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: got %s (t=%0t)", name, what, $time);
  endtask

  // Reference model: split a command into bursts from the page and burst-cap rules.
  task automatic model_cmd(input logic [AW-1:0] a, input longint beats);
    longint unsigned addr = a;
    longint rem = beats;
    longint page;
    longint b;
    while (rem > 0) begin
      page = 512 - longint'((addr % 4096) / 8);
      b = rem;
      if (b > 256)  b = 256;
      if (b > page) b = page;
      exp_awaddr.push_back(AW'(addr));
      exp_awlen.push_back(MLW'(b - 1));
      for (longint k = 0; k < b; k++) exp_last.push_back(k == b - 1);
      addr = (addr / 8) * 8 + longint'(b) * 8;
      rem  = rem - b;
    end
  endtask

  // Ready generators for the downstream side.
  initial begin
    m_awready = 1'b0;
    m_wready  = 1'b0;
    forever begin
      @(posedge clk); #1;
      m_awready = ($urandom % 100) < aw_pct;
      m_wready  = ($urandom % 100) < w_pct;
    end
  end

  // Monitor: compare every downstream handshake against the queued expectations.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_awvalid && m_awready) begin
        aw_hs++;
        aw_beat_sum += longint'(m_awlen) + 1;
        chk("aw_4k_boundary", 64'((m_awaddr % 4096) / 8 + m_awlen + 1 <= 512), 64'd1);
        if (exp_awaddr.size() == 0) fail("aw_unexpected", "burst with empty model queue");
        else begin
          chk("m_awaddr", 64'(m_awaddr), 64'(exp_awaddr.pop_front()));
          chk("m_awlen",  64'(m_awlen),  64'(exp_awlen.pop_front()));
        end
      end
      if (m_wvalid && m_wready) begin
        if (exp_last.size() == 0 || exp_data.size() == 0) fail("w_unexpected", "beat with empty model queue");
        else begin
          chk("m_wlast", 64'(m_wlast), 64'(exp_last.pop_front()));
          chk("m_wdata", m_wdata,      exp_data.pop_front());
          chk("m_wstrb", 64'(m_wstrb), 64'(exp_strb.pop_front()));
        end
      end
    end
  end

  // All drive tasks are entered just after a rising edge.
  task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] len);
    int t = 0;
    if (abort) return;
    model_cmd(a, longint'(len) + 1);
    s_awaddr  = a;
    s_awlen   = len;
    s_awvalid = 1'b1;
    @(negedge clk);
    while (!s_awready && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) begin fail("aw_accept_timeout", "no s_awready"); abort = 1; end
    hs_cyc = cyc;
    @(posedge clk); #1;
    s_awvalid = 1'b0;
  endtask

  task automatic send_beats(input int n, input int max_gap);
    int t;
    for (int i = 0; i < n; i++) begin
      if (abort) return;
      repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
      s_wdata  = ramp;
      s_wstrb  = SW'($urandom);
      s_wvalid = 1'b1;
      exp_data.push_back(s_wdata);
      exp_strb.push_back(s_wstrb);
      ramp = ramp + 1;
      t = 0;
      @(negedge clk);
      while (!s_wready && t < TMO) begin @(negedge clk); t++; end
      if (t >= TMO) begin fail("w_accept_timeout", "no s_wready"); abort = 1; end
      @(posedge clk); #1;
      s_wvalid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_awaddr.size() != 0 || exp_last.size() != 0 || exp_data.size() != 0) &&
           t < 20000 && !abort) begin
      @(negedge clk); t++;
    end
    chk("drain_aw", 64'(exp_awaddr.size()), 64'd0);
    chk("drain_w",  64'(exp_last.size()),   64'd0);
    if (t >= 20000) abort = 1;
    @(posedge clk); #1;
  endtask

  // Reset with s_wvalid high so a surviving FIFO entry would show on m_wvalid.
  task automatic do_reset_check(input string tag);
    reset    = 1'b1;
    s_wvalid = 1'b1;
    exp_awaddr.delete(); exp_awlen.delete(); exp_last.delete();
    exp_data.delete();   exp_strb.delete();
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_s_awready"}, 64'(s_awready), 64'd0);
    chk({tag, "_m_awvalid"}, 64'(m_awvalid), 64'd0);
    chk({tag, "_m_wvalid"},  64'(m_wvalid),  64'd0);
    chk({tag, "_s_wready"},  64'(s_wready),  64'd0);
    chk({tag, "_m_awaddr"},  64'(m_awaddr),  64'd0);
    chk({tag, "_m_awlen"},   64'(m_awlen),   64'd0);
    @(posedge clk); #1;
    reset    = 1'b0;
    s_wvalid = 1'b0;
  endtask

  task automatic basic_16();
    int t = 0;
    aw_pct = 100; w_pct = 100;
    send_cmd('0, 32'd15);
    while (!m_awvalid && t < 20) begin @(negedge clk); t++; end
    chk("aw_latency", 64'(cyc - hs_cyc), 64'd2);
    @(posedge clk); #1;
    send_beats(16, 0);
    wait_drain();
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no completion, expected finish before 90000 cycles");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : main
    int base;
    bit aw_done;
    reset = 1'b1; s_awvalid = 1'b0; s_awaddr = '0; s_awlen = '0;
    s_wvalid = 1'b0; s_wdata = '0; s_wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    do_reset_check("reset");

    // Single burst pass-through with latency check.
    base = aw_hs;
    basic_16();
    chk("basic_burst_count", 64'(aw_hs - base), 64'd1);

    // Burst-cap split.
    base = aw_hs;
    send_cmd('0, 32'd599);
    send_beats(600, 0);
    wait_drain();
    chk("maxburst_count", 64'(aw_hs - base), 64'd3);

    // Page-boundary split and unaligned single beat.
    base = aw_hs;
    send_cmd(AW'('hFF8), 32'd3);
    send_beats(4, 1);
    wait_drain();
    chk("page_split_count", 64'(aw_hs - base), 64'd2);
    base = aw_hs;
    send_cmd(AW'('h1003), 32'd0);
    send_beats(1, 0);
    wait_drain();
    chk("unaligned_count", 64'(aw_hs - base), 64'd1);

    // Command FIFO full: W held off, AW must stop after the FIFO depth.
    aw_pct = 100; w_pct = 0;
    base = aw_hs;
    aw_done = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) send_cmd(AW'(i * 64), 32'd0);
        aw_done = 1;
      end
    join_none
    repeat (150) @(posedge clk);
    #1;
    chk("fifo_full_aw_count", 64'(aw_hs - base), 64'd16);
    chk("fifo_full_awvalid",  64'(m_awvalid),    64'd0);
    chk("fifo_full_awready",  64'(s_awready),    64'd0);
    w_pct = 100;
    send_beats(20, 0);
    for (int t = 0; t < TMO && !aw_done; t++) begin @(posedge clk); #1; end
    wait_drain();
    chk("fifo_full_total", 64'(aw_hs - base), 64'd20);

    // Reset while a long command sits in ISSUE.
    aw_pct = 0; w_pct = 100;
    send_cmd('0, 32'd599);
    for (int t = 0; t < 20 && !m_awvalid; t++) @(negedge clk);
    chk("pre_reset_issue", 64'(m_awvalid), 64'd1);
    @(posedge clk); #1;
    do_reset_check("midreset");
    base = aw_hs;
    basic_16();
    chk("post_reset_count", 64'(aw_hs - base), 64'd1);

    // Random stress with growing commands.
    aw_pct = 60; w_pct = 60;
    base = aw_hs;
    aw_beat_sum = 0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          send_cmd(AW'('hE05 + i * 56), LW'(i));
        end
      end
      send_beats(5050, 1);
    join
    wait_drain();
    chk("stress_beat_sum", 64'(aw_beat_sum), 64'd5050);
    chk("stress_data_left", 64'(exp_data.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
